// File: rtl/mmio_uart_bridge.sv
// mmio_uart_bridge: memory-mapped responder for the 0x8000_0000 region.
// It buffers UART traffic in RX/TX FIFOs and exposes cycle and
// retired-instruction counters to load/store traffic from the execute stage.
module mmio_uart_bridge #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_AWIDTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mmio_addr,
    input  logic        mmio_re,
    input  logic        mmio_we,
    input  logic [3:0]  mmio_wbe,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retired,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [FIFO_AWIDTH:0]   DEPTH_CNT = (FIFO_AWIDTH + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AWIDTH:0]   CNT_ONE   = (FIFO_AWIDTH + 1)'(1);
    localparam logic [FIFO_AWIDTH-1:0] PTR_ONE   = FIFO_AWIDTH'(1);

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_LEVELS = 8'h0C;
    localparam logic [7:0] OFF_CYCLES = 8'h10;
    localparam logic [7:0] OFF_INSTRS = 8'h14;
    localparam logic [7:0] OFF_CLEAR  = 8'h18;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       sel;
    logic [7:0] off;
    logic       ld_status;
    logic       ld_rxdata;
    logic       st_txdata;
    logic       st_clear;

    assign sel       = (mmio_addr[31:28] == 4'h8);
    assign off       = mmio_addr[7:0];
    assign ld_status = mmio_re && sel && (off == OFF_STATUS);
    assign ld_rxdata = mmio_re && sel && (off == OFF_RXDATA);
    assign st_txdata = mmio_we && sel && (off == OFF_TXDATA) && mmio_wbe[0];
    assign st_clear  = mmio_we && sel && (off == OFF_CLEAR);

    // Address bits outside the decoded window and upper store lanes are
    // intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{mmio_addr[27:8], mmio_wdata[31:8], mmio_wbe[3:1]};

    // ------------------------------------------------------------------
    // RX FIFO (uart_receiver -> CPU)
    // ------------------------------------------------------------------
    logic [7:0]             rx_mem [FIFO_DEPTH];
    logic [FIFO_AWIDTH-1:0] rx_wr_ptr;
    logic [FIFO_AWIDTH-1:0] rx_rd_ptr;
    logic [FIFO_AWIDTH:0]   rx_count;
    logic                   rx_full;
    logic                   rx_empty;
    logic                   rx_push;
    logic                   rx_pop;
    logic [7:0]             rx_head;

    assign rx_full  = (rx_count == DEPTH_CNT);
    assign rx_empty = (rx_count == '0);
    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && !rx_full;
    assign rx_pop   = ld_rxdata && !rx_empty;
    assign rx_head  = rx_empty ? '0 : rx_mem[rx_rd_ptr];

    // RX storage write; contents are invalidated by the pointers on reset
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
        end
    end

    // RX pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_ONE;
                2'b01:   rx_count <= rx_count - CNT_ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO (CPU -> uart_transmitter)
    // ------------------------------------------------------------------
    logic [7:0]             tx_mem [FIFO_DEPTH];
    logic [FIFO_AWIDTH-1:0] tx_wr_ptr;
    logic [FIFO_AWIDTH-1:0] tx_rd_ptr;
    logic [FIFO_AWIDTH:0]   tx_count;
    logic                   tx_full;
    logic                   tx_empty;
    logic                   tx_push;
    logic                   tx_pop;
    logic                   tx_drop;
    logic                   tx_drop_set;

    assign tx_full     = (tx_count == DEPTH_CNT);
    assign tx_empty    = (tx_count == '0);
    assign tx_valid    = !tx_empty;
    // Fullness is judged on pre-cycle state, so a same-cycle pop never
    // rescues a store against a full FIFO.
    assign tx_push     = st_txdata && !tx_full;
    assign tx_drop_set = st_txdata && tx_full;
    assign tx_pop      = tx_valid && tx_ready;
    // Gated so the transmitter sees 0 rather than stale storage when idle.
    assign tx_data     = tx_empty ? '0 : tx_mem[tx_rd_ptr];

    // TX storage write; contents are invalidated by the pointers on reset
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= mmio_wdata[7:0];
        end
    end

    // TX pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_ONE;
                2'b01:   tx_count <= tx_count - CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // Sticky drop flag: set by a rejected store, cleared by a status read,
    // with a new drop taking priority over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_drop <= 1'b0;
        end else if (tx_drop_set) begin
            tx_drop <= 1'b1;
        end else if (ld_status) begin
            tx_drop <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] cyc_cnt;
    logic [31:0] inst_cnt;

    // Free-running cycle counter; a clear overrides the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (st_clear) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    // Retired-instruction counter; a clear overrides the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_cnt <= '0;
        end else if (st_clear) begin
            inst_cnt <= '0;
        end else if (inst_retired) begin
            inst_cnt <= inst_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Load data path
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;

    // Select the register addressed by the current load
    always_comb begin
        rd_mux = '0;
        if (sel) begin
            case (off)
                OFF_STATUS: rd_mux = {28'b0, tx_drop, rx_full, !rx_empty, !tx_full};
                OFF_RXDATA: rd_mux = {24'b0, rx_head};
                OFF_LEVELS: rd_mux = {8'b0, 8'(rx_count), 8'b0, 8'(tx_count)};
                OFF_CYCLES: rd_mux = cyc_cnt;
                OFF_INSTRS: rd_mux = inst_cnt;
                default:    rd_mux = '0;
            endcase
        end
    end

    // Registered load data, held between loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_rdata <= '0;
        end else if (mmio_re) begin
            mmio_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Scoreboard bench for mmio_uart_bridge: a queue-based reference model
// predicts load data and TX byte order; a monitor compares DUT outputs.
module tb_mmio_uart_bridge;

    localparam int DEPTH = 8;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mmio_addr = '0;
    logic        mmio_re = 1'b0;
    logic        mmio_we = 1'b0;
    logic [3:0]  mmio_wbe = '0;
    logic [31:0] mmio_wdata = '0;
    logic [31:0] mmio_rdata;
    logic        inst_retired = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        preload = 1'b0;

    mmio_uart_bridge #(.FIFO_DEPTH(DEPTH), .FIFO_AWIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .mmio_addr(mmio_addr), .mmio_re(mmio_re), .mmio_we(mmio_we),
        .mmio_wbe(mmio_wbe), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
        .inst_retired(inst_retired),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  tx_exp[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    bit          m_drop;
    logic [31:0] m_cyc, m_ins;
    logic        ld_vld;
    logic [31:0] m_now, m_val;
    bit          m_sel, m_rxpop, m_rxpush, m_txstore, m_txpop, m_txfull, m_clear;
    logic [7:0]  m_off;
    string       m_nm;

    // Inputs are stable between posedge+1 and the next posedge, so the model
    // evaluates each upcoming clock edge on the preceding falling edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxq.delete(); txq.delete(); tx_exp.delete();
            exp_q.delete(); name_q.delete();
            m_drop = 0; m_cyc = '0; m_ins = '0;
            ld_vld <= 1'b0;
        end else begin
            check("tx_valid", {31'b0, tx_valid}, {31'b0, txq.size() != 0});
            check("rx_ready", {31'b0, rx_ready}, {31'b0, rxq.size() != DEPTH});
            m_now = preload ? 32'hFFFF_FFFF : m_cyc;
            m_sel = (mmio_addr[31:28] == 4'h8);
            m_off = mmio_addr[7:0];
            if (mmio_re) begin
                m_val = '0;
                m_nm  = "rd_unmapped";
                if (m_sel) begin
                    case (m_off)
                        8'h00: begin
                            m_val = {28'b0, m_drop, rxq.size() == DEPTH, rxq.size() != 0, txq.size() != DEPTH};
                            m_nm = "rd_status";
                        end
                        8'h04: begin
                            m_val = (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h0;
                            m_nm = "rd_rxdata";
                        end
                        8'h0C: begin
                            m_val = {8'b0, 8'(rxq.size()), 8'b0, 8'(txq.size())};
                            m_nm = "rd_levels";
                        end
                        8'h10: begin m_val = m_now; m_nm = "rd_cycles"; end
                        8'h14: begin m_val = m_ins; m_nm = "rd_instret"; end
                        default: ;
                    endcase
                end
                exp_q.push_back(m_val);
                name_q.push_back(m_nm);
            end
            ld_vld <= mmio_re;

            m_rxpop   = mmio_re && m_sel && m_off == 8'h04 && rxq.size() != 0;
            m_rxpush  = rx_valid && rxq.size() != DEPTH;
            m_txfull  = (txq.size() == DEPTH);
            m_txstore = mmio_we && m_sel && m_off == 8'h08 && mmio_wbe[0];
            m_txpop   = tx_ready && txq.size() != 0;
            m_clear   = mmio_we && m_sel && m_off == 8'h18;

            if (m_rxpop) void'(rxq.pop_front());
            if (m_rxpush) rxq.push_back(rx_data);
            if (m_txpop) void'(txq.pop_front());
            if (m_txstore && !m_txfull) begin
                txq.push_back(mmio_wdata[7:0]);
                tx_exp.push_back(mmio_wdata[7:0]);
            end
            if (m_txstore && m_txfull) m_drop = 1;
            else if (mmio_re && m_sel && m_off == 8'h00) m_drop = 0;
            m_cyc = m_clear ? 32'h0 : m_now + 32'd1;
            m_ins = m_clear ? 32'h0 : m_ins + {31'b0, inst_retired};
        end
    end

    // ---------------- monitor ----------------
    logic [31:0] mon_exp;
    string       mon_nm;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ld_vld) begin
                if (exp_q.size() == 0) begin
                    check("rdata_no_expectation", mmio_rdata, 32'hDEAD_BEEF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_nm  = name_q.pop_front();
                    check(mon_nm, mmio_rdata, mon_exp);
                end
            end
            if (tx_valid && tx_ready) begin
                if (tx_exp.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: got 0x%02h, required no byte at %0t", tx_data, $time);
                end else begin
                    check("tx_data", {24'b0, tx_data}, {24'b0, tx_exp.pop_front()});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] o);
        mmio_addr = BASE | {24'b0, o};
        mmio_re = 1'b1;
        step();
        mmio_re = 1'b0;
    endtask

    task automatic store(input logic [7:0] o, input logic [31:0] d, input logic [3:0] be);
        mmio_addr = BASE | {24'b0, o};
        mmio_we = 1'b1;
        mmio_wdata = d;
        mmio_wbe = be;
        step();
        mmio_we = 1'b0;
    endtask

    logic [7:0] offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'hFC};

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        check("reset_rdata", mmio_rdata, 32'h0);
        check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("reset_rx_ready", {31'b0, rx_ready}, 32'h1);
        check("reset_tx_data", {24'b0, tx_data}, 32'h0);
        rst_n = 1'b1;
        step();
        load(8'h00);
        step();

        // three bytes held back, then drained in order
        tx_ready = 1'b0;
        store(8'h08, 32'h0000_0041, 4'hF);
        store(8'h08, 32'h0000_0042, 4'h1);
        store(8'h08, 32'h0000_0043, 4'hF);
        store(8'h08, 32'h0000_00EE, 4'hE);   // lane 0 disabled: ignored
        load(8'h0C);
        tx_ready = 1'b1;
        repeat (5) step();

        // overflow and sticky drop
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) store(8'h08, 32'hA0 + i, 4'hF);
        load(8'h00);
        load(8'h00);
        store(8'h08, 32'h0000_00B0, 4'hF);   // dropped again
        tx_ready = 1'b1;                     // pop does not rescue a full push
        store(8'h08, 32'h0000_00B1, 4'hF);
        load(8'h00);
        repeat (10) step();
        load(8'h0C);

        // RX fill, overflow attempt, drain past empty
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h10 + 8'(i);
            rx_valid = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        load(8'h00);
        for (int i = 0; i < 9; i++) load(8'h04);
        load(8'h0C);
        rx_data = 8'h55; rx_valid = 1'b1; step();
        rx_data = 8'h66; load(8'h04);        // push and pop together
        rx_valid = 1'b0;
        load(8'h0C);
        load(8'h04);

        // counters
        repeat (100) step();
        load(8'h10);
        store(8'h18, 32'h0, 4'h0);
        load(8'h10);
        load(8'h10);
        repeat (5) begin
            inst_retired = 1'b1; step();
            inst_retired = 1'b0; step();
        end
        load(8'h14);
        inst_retired = 1'b1;
        store(8'h18, 32'hFFFF_FFFF, 4'hF);   // clear beats increment
        load(8'h14);
        inst_retired = 1'b0;
        load(8'h14);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            mmio_re = ($urandom_range(0, 2) == 0);
            mmio_we = ($urandom_range(0, 2) == 0);
            mmio_addr = BASE | ($urandom & 32'h0FFF_FF00) | {24'b0, offs[$urandom_range(0, 9)]};
            if (!mmio_re && $urandom_range(0, 5) == 0) mmio_addr[31:28] = 4'(($urandom_range(0, 1) == 0) ? 4'h0 : 4'h9);
            if (mmio_we && mmio_addr[7:0] == 8'h18 && $urandom_range(0, 3) != 0) mmio_we = 1'b0;
            mmio_wdata = $urandom;
            mmio_wbe = 4'($urandom);
            rx_valid = $urandom_range(0, 1) == 1;
            rx_data = 8'($urandom);
            tx_ready = $urandom_range(0, 2) != 0;
            inst_retired = $urandom_range(0, 1) == 1;
            step();
        end
        mmio_re = 1'b0; mmio_we = 1'b0; rx_valid = 1'b0; inst_retired = 1'b0;
        tx_ready = 1'b1;
        repeat (12) step();
        load(8'h0C);

        // cycle counter wrap
        force dut.cyc_cnt = 32'hFFFF_FFFF;
        preload = 1'b1;
        mmio_addr = BASE | 32'h10;
        mmio_re = 1'b1;
        #3;
        release dut.cyc_cnt;
        step();
        preload = 1'b0;
        mmio_re = 1'b0;
        load(8'h10);

        // asynchronous reset during transmission
        tx_ready = 1'b0;
        store(8'h08, 32'h61, 4'hF);
        store(8'h08, 32'h62, 4'hF);
        store(8'h08, 32'h63, 4'hF);
        tx_ready = 1'b1;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("async_rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        check("async_rst_rdata", mmio_rdata, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        load(8'h0C);
        load(8'h00);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
